// File: rtl/vpi_counter_pkg.sv
// Shared encodings for the multi-channel counter bank: config field selects and mode bits.
package vpi_counter_pkg;

  localparam logic [1:0] SEL_STEP = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_CMP  = 2'd2;
  localparam logic [1:0] SEL_MODE = 2'd3;

  localparam int unsigned MODE_SAT  = 0;
  localparam int unsigned MODE_DOWN = 1;

endpackage

// File: rtl/vpi_counter_bank_if.sv
// Control/status bundle of the counter bank; the bank is the slave side.
interface vpi_counter_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

  logic [NUM_CH-1:0]       en;
  logic                    cfg_we;
  logic [CH_W-1:0]         cfg_ch;
  logic [1:0]              cfg_sel;
  logic [WIDTH-1:0]        cfg_wdata;
  logic [NUM_CH-1:0]       ovf_clr;
  logic [NUM_CH*WIDTH-1:0] cnt;
  logic [NUM_CH-1:0]       match;
  logic [NUM_CH-1:0]       ovf;

  modport master (
    output en, cfg_we, cfg_ch, cfg_sel, cfg_wdata, ovf_clr,
    input  cnt, match, ovf
  );

  modport slave (
    input  en, cfg_we, cfg_ch, cfg_sel, cfg_wdata, ovf_clr,
    output cnt, match, ovf
  );

endinterface

// File: rtl/vpi_counter_chan.sv
// One counter channel: programmable step/compare/mode, sticky overflow and registered match pulse.
module vpi_counter_chan
  import vpi_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step_we,
  input  logic             load_we,
  input  logic             cmp_we,
  input  logic             mode_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             match,
  output logic             ovf
);

  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] cmp;
  logic [1:0]       mode;

  logic [WIDTH:0]   sum;
  logic             carry;
  logic             count;
  logic [WIDTH-1:0] cnt_nxt;

  // Bit WIDTH of the extended sum is the carry (up) or borrow (down).
  always_comb begin
    count = en && !load_we;
    if (mode[MODE_DOWN]) begin
      sum = {1'b0, cnt} - {1'b0, step};
    end else begin
      sum = {1'b0, cnt} + {1'b0, step};
    end
    carry   = sum[WIDTH];
    cnt_nxt = sum[WIDTH-1:0];
    if (carry && mode[MODE_SAT]) begin
      cnt_nxt = mode[MODE_DOWN] ? '0 : '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      step  <= WIDTH'(1);
      cmp   <= '1;
      mode  <= 2'b00;
      ovf   <= 1'b0;
      match <= 1'b0;
    end else begin
      if (load_we) begin
        cnt <= wdata;
      end else if (en) begin
        cnt <= cnt_nxt;
      end
      match <= count && (cnt_nxt == cmp);
      // A fresh overflow outranks a clear in the same cycle.
      if (count && carry) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (step_we) step <= wdata;
      if (cmp_we)  cmp  <= wdata;
      if (mode_we) mode <= wdata[1:0];
    end
  end

endmodule

// File: rtl/vpi_counter_bank.sv
// NUM_CH independent counters; decodes config writes per channel and packs channel outputs.
module vpi_counter_bank
  import vpi_counter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic               clk,
  input logic               rst,
  vpi_counter_bank_if.slave bus
);

  logic [WIDTH-1:0] cnt_a   [NUM_CH];
  logic             match_a [NUM_CH];
  logic             ovf_a   [NUM_CH];

  // Channel numbers at or above NUM_CH match no instance, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    vpi_counter_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en[i]),
      .step_we (hit && (bus.cfg_sel == SEL_STEP)),
      .load_we (hit && (bus.cfg_sel == SEL_LOAD)),
      .cmp_we  (hit && (bus.cfg_sel == SEL_CMP)),
      .mode_we (hit && (bus.cfg_sel == SEL_MODE)),
      .wdata   (bus.cfg_wdata),
      .ovf_clr (bus.ovf_clr[i]),
      .cnt     (cnt_a[i]),
      .match   (match_a[i]),
      .ovf     (ovf_a[i])
    );
  end

  always_comb begin
    bus.cnt   = '0;
    bus.match = '0;
    bus.ovf   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.cnt[i*WIDTH +: WIDTH] = cnt_a[i];
      bus.match[i]              = match_a[i];
      bus.ovf[i]                = ovf_a[i];
    end
  end

endmodule

// File: tb/tb_vpi_counter_bank.sv
// Scoreboard bench for vpi_counter_bank at WIDTH=8, NUM_CH=4 (cfg_ch widened to reach channel 5).
module tb_vpi_counter_bank;
  import vpi_counter_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CH_W   = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vpi_counter_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  vpi_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string            tag;
    int               ch;
    logic [WIDTH-1:0] cnt;
    logic             match;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_ch(input string tag, input int ch, input int c, input logic m, input logic o);
    exp_t e;
    e.tag   = tag;
    e.ch    = ch;
    e.cnt   = WIDTH'(c);
    e.match = m;
    e.ovf   = o;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".cnt"},   32'(bus.cnt[e.ch*WIDTH +: WIDTH]), 32'(e.cnt));
      check({e.tag, ".match"}, 32'(bus.match[e.ch]),              32'(e.match));
      check({e.tag, ".ovf"},   32'(bus.ovf[e.ch]),                32'(e.ovf));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    bus.cfg_we  = 1'b0;
    bus.ovf_clr = '0;
  endtask

  task automatic cfg_wr(input int ch, input logic [1:0] sel, input int d);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_sel   = sel;
    bus.cfg_wdata = WIDTH'(d);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.en        = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_sel   = SEL_STEP;
    bus.cfg_wdata = '0;
    bus.ovf_clr   = '0;

    // Reset state
    for (int c = 0; c < 4; c++) expect_ch($sformatf("rst_ch%0d", c), c, 0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // ch0 counts five times by the default step of 1
    bus.en = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      expect_ch($sformatf("c0_up%0d", k), 0, k, 1'b0, 1'b0);
      tick();
    end
    bus.en = '0;
    for (int c = 1; c < 4; c++) expect_ch($sformatf("idle_ch%0d", c), c, 0, 1'b0, 1'b0);
    drain();

    // ch1 wrap/up overflow, stickiness and clear
    cfg_wr(1, SEL_STEP, 3);
    tick();
    cfg_wr(1, SEL_LOAD, 250);
    expect_ch("c1_load", 1, 250, 1'b0, 1'b0);
    tick();
    bus.en = 4'b0010;
    expect_ch("c1_253", 1, 253, 1'b0, 1'b0);
    tick();
    expect_ch("c1_wrap", 1, 0, 1'b0, 1'b1);
    tick();
    bus.en = '0;
    expect_ch("c1_sticky", 1, 0, 1'b0, 1'b1);
    tick();
    bus.ovf_clr = 4'b0010;
    expect_ch("c1_clr", 1, 0, 1'b0, 1'b0);
    tick();

    // ch2 saturate/up, then saturate/down
    cfg_wr(2, SEL_MODE, 1);
    tick();
    cfg_wr(2, SEL_LOAD, 254);
    expect_ch("c2_load", 2, 254, 1'b0, 1'b0);
    tick();
    bus.en = 4'b0100;
    expect_ch("c2_sat1", 2, 255, 1'b1, 1'b0);
    tick();
    expect_ch("c2_sat2", 2, 255, 1'b1, 1'b1);
    tick();
    expect_ch("c2_sat3", 2, 255, 1'b1, 1'b1);
    tick();
    bus.en = '0;
    cfg_wr(2, SEL_MODE, 3);
    tick();
    cfg_wr(2, SEL_LOAD, 2);
    expect_ch("c2_load2", 2, 2, 1'b0, 1'b1);
    tick();
    cfg_wr(2, SEL_STEP, 5);
    tick();
    bus.en = 4'b0100;
    expect_ch("c2_floor", 2, 0, 1'b0, 1'b1);
    tick();
    bus.en = '0;

    // ch3 compare match only when counting onto cmp
    cfg_wr(3, SEL_CMP, 10);
    tick();
    cfg_wr(3, SEL_STEP, 2);
    tick();
    cfg_wr(3, SEL_LOAD, 0);
    tick();
    bus.en = 4'b1000;
    for (int k = 1; k <= 7; k++) begin
      expect_ch($sformatf("c3_cnt%0d", k), 3, 2 * k, (k == 5), 1'b0);
      tick();
    end
    bus.en = '0;
    cfg_wr(3, SEL_LOAD, 10);
    expect_ch("c3_load_nomatch", 3, 10, 1'b0, 1'b0);
    tick();
    expect_ch("c3_hold", 3, 10, 1'b0, 1'b0);
    tick();

    // ch0 same-cycle priorities
    bus.en = 4'b0001;
    cfg_wr(0, SEL_LOAD, 100);
    expect_ch("c0_load_beats_en", 0, 100, 1'b0, 1'b0);
    tick();
    bus.en = '0;
    cfg_wr(0, SEL_LOAD, 255);
    expect_ch("c0_load255", 0, 255, 1'b0, 1'b0);
    tick();
    bus.en      = 4'b0001;
    bus.ovf_clr = 4'b0001;
    expect_ch("c0_set_beats_clr", 0, 0, 1'b0, 1'b1);
    tick();
    cfg_wr(0, SEL_STEP, 7);
    expect_ch("c0_old_step", 0, 1, 1'b0, 1'b1);
    tick();
    expect_ch("c0_new_step", 0, 8, 1'b0, 1'b1);
    tick();
    bus.en = '0;

    // Out-of-range channel write touches nothing
    cfg_wr(5, SEL_LOAD, 77);
    expect_ch("oor_ch0", 0, 8, 1'b0, 1'b1);
    expect_ch("oor_ch1", 1, 0, 1'b0, 1'b0);
    expect_ch("oor_ch2", 2, 0, 1'b0, 1'b1);
    expect_ch("oor_ch3", 3, 10, 1'b0, 1'b0);
    tick();

    // Asynchronous reset mid-count
    cfg_wr(0, SEL_CMP, 47);
    tick();
    cfg_wr(0, SEL_LOAD, 40);
    expect_ch("c0_load40", 0, 40, 1'b0, 1'b1);
    tick();
    bus.en = 4'b0001;
    expect_ch("c0_47", 0, 47, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    #2;
    for (int c = 0; c < 4; c++) expect_ch($sformatf("async_rst_ch%0d", c), c, 0, 1'b0, 1'b0);
    drain();
    tick();
    rst = 1'b0;
    expect_ch("post_rst_c0", 0, 1, 1'b0, 1'b0);
    expect_ch("post_rst_c2", 2, 0, 1'b0, 1'b0);
    tick();
    bus.en = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vpi_counter_bank.md
Name: vpi_counter_bank

Overview:
Multi-channel, parametrised successor to the single free-running counter demo used for internal-signal access. NUM_CH independent counters of WIDTH bits, each with its own programmable step, compare value and mode. Modes select up or down counting and wrap or saturate. Each channel has a sticky overflow flag and a compare-match pulse. Sits in the InternalSignals examples as the richer target for reading and forcing internal registers.

Parameters:
NUM_CH, 4, number of counter channels
WIDTH, 32, counter/step/compare width in bits
CH_W, $clog2(NUM_CH) (min 1), channel-select width (derived)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
en  input  NUM_CH  per-channel count enable
cfg_we  input  1  config write strobe
cfg_ch  input  CH_W  target channel of config write
cfg_sel  input  2  target field: 0 step, 1 count load, 2 compare, 3 mode
cfg_wdata  input  WIDTH  write data; for mode only bits [1:0] are used
ovf_clr  input  NUM_CH  per-channel sticky-overflow clear
cnt  output  NUM_CH*WIDTH  packed counter values, channel i at [i*WIDTH +: WIDTH]
match  output  NUM_CH  one-cycle compare-match pulse
ovf  output  NUM_CH  sticky overflow/underflow flag

Behaviour:
- Reset (async assert, sync deassert at next edge): cnt=0, step=1, cmp=all-ones, mode=0, ovf=0, match=0 for every channel. Assertion mid-count clears state immediately, without waiting for a clock edge.
- Mode bits: bit0 0=wrap, 1=saturate; bit1 0=up, 1=down.
- Per channel, when en[i] is high and there is no count load to channel i this cycle:
  - Compute the next value at WIDTH+1 bits: up = cnt+step, down = cnt-step.
  - Carry/borrow in bit WIDTH means overflow.
  - Wrap: cnt <= low WIDTH bits.
  - Saturate: cnt <= all-ones (up) or 0 (down).
  - Either mode: ovf[i] <= 1 on overflow.
- en[i] low: cnt holds.
- Latency: cnt updates one cycle after the enabled edge; outputs are direct register outputs, with no combinational path from inputs.
- Config write takes effect at the edge where cfg_we=1. If cfg_ch >= NUM_CH, the write is ignored.
- Load vs enable: a count load (sel=1) to channel i beats en[i] in the same cycle. cnt <= cfg_wdata, with no step applied, no ovf and no match.
- Step/compare/mode write with en[i] in the same cycle: that cycle's count uses the old value; the new value applies from the next cycle.
- match[i] is registered. It is 1 in the cycle cnt[i] takes a value equal to cmp[i] through counting (not through a load), otherwise 0.
  - With step=0 and cnt==cmp, match fires on every enabled cycle.
- Saturated at limit with en and further overflow: cnt stays at the limit, ovf stays 1.
- ovf_clr[i] clears ovf[i]. If an overflow occurs in the same cycle, set wins and ovf[i] stays 1.
- step, cmp and mode are plain per-channel registers that remain readable and forceable through internal-signal access. They are not optimised away or merged.

Decomposition:
- Package vpi_counter_pkg holds:
  - cfg_sel encodings (SEL_STEP=0, SEL_LOAD=1, SEL_CMP=2, SEL_MODE=3)
  - mode bit indices (MODE_SAT=0, MODE_DOWN=1)
- Sub-module vpi_counter_chan implements one channel (cnt, step, cmp, mode, ovf, match). It is generate-instantiated NUM_CH times.
- The top level decodes cfg_ch into per-channel write enables and packs cnt.

Test Plan:
All scenarios use WIDTH=8, NUM_CH=4.
- Reset, then en=4'b0001 for 5 cycles -> cnt0=5; cnt1..3=0; ovf=0; match=0.
- ch1 wrap/up, step=3, load 250, en1 for 2 cycles -> cnt1 253 then 0; ovf[1]=1 and stays 1; pulse ovf_clr[1] with en1=0 -> ovf[1]=0.
- ch2 saturate/up, load 254, en2 for 3 cycles -> 255, 255, 255; ovf[2]=1 from the 2nd cycle. Then mode=3, load 2, step=5, en2 for 1 cycle -> cnt2=0, ovf[2]=1.
- ch3 cmp=10, step=2 from 0, en3 for 7 cycles -> match[3] high only in the cycle cnt3=10 (5th count); load 10 afterwards -> no match.
- Same cycle on ch0: load 100 with en0=1 -> cnt0=100 (not 101). Overflow with ovf_clr[0]=1 in the same cycle -> ovf[0]=1. Write with cfg_ch=5 -> no channel changes.
- While ch0 counts at 40, assert rst between clock edges -> cnt, ovf and match go to 0 immediately; after release, the first enabled edge gives cnt0=1 (step restored to 1).
